iter_multiplier: RTL
====================

ITER_MULTIPLIER -- requirements
Module: iter_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width; even, >= 4.
REQ-002 SHALL have parameter RADIX_BITS, default 2: multiplier bits consumed per cycle; SHALL divide WIDTH, elaboration error otherwise.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op  input  2  00 mul, 01 mulh, 10 mulhsu, 11 mulhu (RV32M funct3[1:0]).
REQ-007 a  input  WIDTH  multiplicand (rs1); sampled with start.
REQ-008 b  input  WIDTH  multiplier (rs2); sampled with start.
REQ-009 flush  input  1  abort in-flight operation.
REQ-010 busy  output  1  high in CALC and DONE.
REQ-011 done  output  1  one-cycle pulse; result valid this cycle.
REQ-012 result  output  WIDTH  registered product slice; held until next done.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-014 IDLE, start=1, flush=0: latch |a|, |b|, op, result sign; next state CALC.
- mul/mulh: both signed; mulhsu: a signed, b unsigned; mulhu: both unsigned.
- magnitude of most-negative value SHALL be 2^(WIDTH-1) as WIDTH-bit unsigned.
REQ-015 CALC each cycle: acc += (low RADIX_BITS of mcand-multiplier) x mcand_shifted; mcand_shifted <<= RADIX_BITS; multiplier >>= RADIX_BITS; acc 2*WIDTH bits, no overflow.
REQ-016 CALC SHALL run WIDTH/RADIX_BITS iterations (N), then DONE (modifiable per REQ-027).
REQ-017 DONE: done=1 one cycle; result registered same edge DONE is entered; next state IDLE.
REQ-018 Sign fix: if result sign=1, product = two's complement of acc (2*WIDTH bits).
REQ-019 Result slice: mul -> product[WIDTH-1:0]; mulh/mulhsu/mulhu -> product[2*WIDTH-1:WIDTH].
REQ-020 Latency without macro: start sampled edge 0 -> done high in cycle N+1 (17 at defaults).
REQ-021 start while busy SHALL be ignored; no queueing.
REQ-022 flush in CALC or DONE: next state IDLE, done forced 0 that cycle and after, result unchanged.
REQ-023 flush and start same IDLE cycle: flush wins, no operation launched.
REQ-024 start accepted in the IDLE cycle directly after DONE (back-to-back throughput N+2).

Reset
REQ-025 rst=1 SHALL immediately force IDLE, busy=0, done=0, result=0, acc/operand regs=0, regardless of state.
REQ-026 Reset mid-CALC SHALL produce no done after release; first start after release behaves as from power-up.

Configuration
REQ-027 Macro ITER_MULTIPLIER_EARLY_TERM_EN:
- defined: CALC exits after iteration in which remaining multiplier becomes 0; iterations = max(1, k), k = index of highest nonzero RADIX_BITS group of |b| plus 1 (k=0 for b=0); done in cycle 1+max(1,k).
- undefined: fixed N iterations per REQ-016; results bit-identical in both builds.

Verification (WIDTH=32, RADIX_BITS=2)
REQ-028 mulh a=0x80000000 b=0x80000000 -> result 0x40000000; mul same operands -> 0x00000000.
REQ-029 mulhsu a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFF; mulhu same -> 0xFFFFFFFE.
REQ-030 mul a=7 b=0xFFFFFFFD -> 0xFFFFFFEB; done at cycle 17 without macro, cycle 2 with macro (|b|=3, k=1).
REQ-031 mul a=0x12345678 b=0 with macro -> done cycle 2, result 0; without -> done cycle 17, result 0.
REQ-032 start mulhu, flush at cycle 5 -> no done, busy=0 cycle 6, result unchanged; new start cycle 6 completes normally.
REQ-033 rst asserted cycle 8 of CALC -> busy, done, result 0 immediately; no done after release; start with start/flush both high in IDLE -> busy stays 0.

Source files
------------

// File: rtl/iter_multiplier.sv
// ---------------------------------------------------------------------------
// iter_multiplier
//
// Iterative RV32M-style multiplier. The operands are converted to magnitudes
// at launch. RADIX_BITS multiplier bits are consumed per cycle by a
// shift-and-add loop into a 2*WIDTH accumulator. The sign is applied once,
// on the final sum. The FSM walks IDLE -> CALC -> DONE -> IDLE.
//
// Optional feature macro: ITER_MULTIPLIER_EARLY_TERM_EN
//   defined   : CALC exits once the remaining multiplier has shifted to zero
//               (at least one iteration always runs).
//   undefined : CALC always runs WIDTH/RADIX_BITS iterations.
//   Results are bit-identical in both builds; only the latency changes.
//
// Parameters
//   WIDTH       operand/result width (even, >= 4)
//   RADIX_BITS  multiplier bits consumed per cycle (must divide WIDTH)
//
// Ports
//   clk     in   sole clock, rising edge
//   rst     in   asynchronous active-high reset
//   start   in   launch request, sampled only in IDLE
//   op      in   00 mul, 01 mulh, 10 mulhsu, 11 mulhu
//   a       in   multiplicand (rs1), sampled with start
//   b       in   multiplier (rs2), sampled with start
//   flush   in   abort the in-flight operation
//   busy    out  high while in CALC or DONE
//   done    out  one-cycle pulse, result valid this cycle
//   result  out  registered product slice, held until the next done
// ---------------------------------------------------------------------------
module iter_multiplier #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int N     = WIDTH / RADIX_BITS;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    generate
        if ((WIDTH % RADIX_BITS) != 0) begin : g_bad_radix
            $error("iter_multiplier: RADIX_BITS must divide WIDTH");
        end
        if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("iter_multiplier: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q,  state_d;
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [1:0]           op_q,     op_d;
    logic                 neg_q,    neg_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;

    logic                 a_signed_s, b_signed_s;
    logic                 a_neg_s,    b_neg_s;
    logic [WIDTH-1:0]     a_mag_s,    b_mag_s;
    logic [RADIX_BITS-1:0] digit_s;
    logic [2*WIDTH-1:0]   pp_s;
    logic [2*WIDTH-1:0]   acc_sum_s;
    logic [2*WIDTH-1:0]   product_s;
    logic [WIDTH-1:0]     mplier_shr_s;
    logic                 last_iter_s;

    // Operand conditioning, one radix step and next-state/output decode.
    always_comb begin
        // Signedness per op; mulhu treats both operands as unsigned.
        a_signed_s = (op != OP_MULHU);
        b_signed_s = (op == OP_MUL) || (op == OP_MULH);
        a_neg_s    = a_signed_s & a[WIDTH-1];
        b_neg_s    = b_signed_s & b[WIDTH-1];
        // The most-negative value negates to itself, read as unsigned 2^(W-1).
        a_mag_s    = a_neg_s ? (~a + WIDTH'(1)) : a;
        b_mag_s    = b_neg_s ? (~b + WIDTH'(1)) : b;

        // Partial product of the current digit with the shifted multiplicand.
        digit_s = mplier_q[RADIX_BITS-1:0];
        pp_s    = '0;
        for (int j = 0; j < RADIX_BITS; j++) begin
            if (digit_s[j]) begin
                pp_s = pp_s + (mcand_q << j);
            end else begin
                pp_s = pp_s;
            end
        end
        acc_sum_s    = acc_q + pp_s;
        mplier_shr_s = mplier_q >> RADIX_BITS;
        // The result is taken from this iteration's sum, so it is ready on the
        // same edge that enters DONE.
        product_s    = neg_q ? (~acc_sum_s + (2*WIDTH)'(1)) : acc_sum_s;

`ifdef ITER_MULTIPLIER_EARLY_TERM_EN
        last_iter_s = (cnt_q == LAST_CNT) || (mplier_shr_s == '0);
`else
        last_iter_s = (cnt_q == LAST_CNT);
`endif

        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                // A flush in the same cycle as start blocks the launch.
                if (start && !flush) begin
                    state_d  = S_CALC;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, a_mag_s};
                    mplier_d = b_mag_s;
                    op_d     = op;
                    neg_d    = a_neg_s ^ b_neg_s;
                    cnt_d    = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d    = acc_sum_s;
                    mcand_d  = mcand_q << RADIX_BITS;
                    mplier_d = mplier_shr_s;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (last_iter_s) begin
                        state_d = S_DONE;
                        if (op_q == OP_MUL) begin
                            result_d = product_s[WIDTH-1:0];
                        end else begin
                            result_d = product_s[2*WIDTH-1:WIDTH];
                        end
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // FSM and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            op_q     <= 2'b00;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    // A flush arriving during DONE suppresses the pulse in that same cycle.
    assign done   = done_q & ~flush;
    assign result = result_q;

endmodule
